// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier.
// Optional feature macro used by this slice: MULT_ZERO_SKIP_EN.
package mult_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    localparam logic [1:0] SHIFT_0 = 2'd0;
    localparam logic [1:0] SHIFT_4 = 2'd1;
    localparam logic [1:0] SHIFT_8 = 2'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STEP0 = 3'd1,
        STEP1 = 3'd2,
        STEP2 = 3'd3,
        STEP3 = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/mult8_step_decode.sv
// Combinational decode of the multiplier state into nibble selects,
// shifter select and busy.
module mult8_step_decode
    import mult_pkg::*;
(
    input  logic [2:0]      state,
    input  logic [OP_W-1:0] a_reg,
    input  logic [OP_W-1:0] b_reg,
    output logic [3:0]      mult_a,
    output logic [3:0]      mult_b,
    output logic [1:0]      shift_cntr,
    output logic            busy
);

    always_comb begin
        mult_a     = 4'd0;
        mult_b     = 4'd0;
        shift_cntr = SHIFT_0;
        busy       = 1'b1;
        case (state)
            STEP0: begin
                mult_a = a_reg[3:0];
                mult_b = b_reg[3:0];
            end
            STEP1: begin
                mult_a     = a_reg[7:4];
                mult_b     = b_reg[3:0];
                shift_cntr = SHIFT_4;
            end
            STEP2: begin
                mult_a     = a_reg[3:0];
                mult_b     = b_reg[7:4];
                shift_cntr = SHIFT_4;
            end
            STEP3: begin
                mult_a     = a_reg[7:4];
                mult_b     = b_reg[7:4];
                shift_cntr = SHIFT_8;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: rtl/mult8_sequencer.sv
// FSM and accumulator of the sequential 8x8 multiplier.
// MULT_ZERO_SKIP_EN: a zero operand finishes immediately with product 0.
module mult8_sequencer
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OP_W-1:0]   dataa,
    input  logic [OP_W-1:0]   datab,
    output logic [3:0]        mult_a,
    output logic [3:0]        mult_b,
    output logic [1:0]        shift_cntr,
    input  logic [PROD_W-1:0] shift_in,
    output logic              busy,
    output logic              done_flag,
    output logic [PROD_W-1:0] product_out
);

    state_t              state;
    state_t              state_nx;
    logic [OP_W-1:0]     a_reg;
    logic [OP_W-1:0]     b_reg;
    logic [PROD_W-1:0]   acc;
    logic                accept;
    logic                zero_op;

    assign accept = start && (state == IDLE || state == DONE);

`ifdef MULT_ZERO_SKIP_EN
    assign zero_op = (dataa == '0) || (datab == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_reg <= dataa;
                b_reg <= datab;
                acc   <= '0;
            end else if (busy) begin
                acc <= acc + shift_in;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = zero_op ? DONE : STEP0;
            STEP0:      state_nx = STEP1;
            STEP1:      state_nx = STEP2;
            STEP2:      state_nx = STEP3;
            STEP3:      state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        done_flag   = (state == DONE);
        product_out = acc;
    end

    mult8_step_decode u_decode (
        .state      (state),
        .a_reg      (a_reg),
        .b_reg      (b_reg),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .shift_cntr (shift_cntr),
        .busy       (busy)
    );

endmodule

// File: tb/tb_mult8_sequencer.sv
// Scoreboard bench for mult8_sequencer with a behavioural 4x4 multiplier
// and nibble shifter closing the external datapath loop.
module tb_mult8_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;
    logic [3:0]  mult_a;
    logic [3:0]  mult_b;
    logic [1:0]  shift_cntr;
    logic [15:0] shift_in;
    logic        busy;
    logic        done_flag;
    logic [15:0] product_out;

    typedef struct {
        logic [15:0] prod;
        int          k;
        bit          zero;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic prev_done = 1'b0;

    mult8_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dataa       (dataa),
        .datab       (datab),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .shift_cntr  (shift_cntr),
        .shift_in    (shift_in),
        .busy        (busy),
        .done_flag   (done_flag),
        .product_out (product_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb
        shift_in = ({12'd0, mult_a} * {12'd0, mult_b}) << {shift_cntr, 2'b00};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (done_flag && !prev_done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e   = q.pop_front();
                    lat = cyc - e.k;
                    chk("product", {16'd0, product_out}, {16'd0, e.prod});
`ifdef MULT_ZERO_SKIP_EN
                    if (e.zero) chk("latency_le1", {31'd0, lat <= 1}, 32'd1);
                    else        chk("latency", lat, 32'd4);
`else
                    chk("latency", lat, 32'd4);
`endif
                end
            end
            prev_done = done_flag;
        end
    end

    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] p);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        dataa = a;
        datab = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        e.prod = p;
        e.k    = cyc;
        e.zero = (a == 8'd0) || (b == 8'd0);
        q.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(done_flag && q.size() == 0) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 40) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [1:0] sc [4];
        logic [3:0] na [4];
        logic [3:0] nb [4];
        sc = '{2'd0, 2'd1, 2'd1, 2'd2};
        na = '{4'h2, 4'h1, 4'h2, 4'h1};
        nb = '{4'h4, 4'h4, 4'h3, 4'h3};

        // reset held with start asserted
        rst_n = 1'b0;
        start = 1'b1;
        dataa = 8'hFF;
        datab = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done_flag}, 32'd0);
        chk("rst_prod", {16'd0, product_out}, 32'd0);
        chk("rst_nibbles", {24'd0, mult_a, mult_b}, 32'd0);
        chk("rst_shift", {30'd0, shift_cntr}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", {31'd0, busy}, 32'd0);

        // 0xFF x 0xFF, shift select sequence
        do_op(8'hFF, 8'hFF, 16'hFE01);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("ff_shift", {30'd0, shift_cntr}, {30'd0, sc[i]});
            chk("ff_busy", {31'd0, busy}, 32'd1);
        end
        wait_done();

        // 0x07 x 0x03, partial sums
        do_op(8'h07, 8'h03, 16'h0015);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("partial_sum", {16'd0, product_out}, 32'h15);
        end
        wait_done();

        // start during STEP2 is ignored
        do_op(8'h55, 8'h0F, 16'h04FB);
        repeat (3) @(negedge clk);
        start = 1'b1;
        dataa = 8'h99;
        datab = 8'h99;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        // back-to-back start from DONE
        do_op(8'h12, 8'h34, 16'h03A8);
        chk("b2b_done_drop", {31'd0, done_flag}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("nib_a", {28'd0, mult_a}, {28'd0, na[i]});
            chk("nib_b", {28'd0, mult_b}, {28'd0, nb[i]});
        end
        wait_done();

        // reset during STEP1 discards the operation
        do_op(8'hAB, 8'hCD, 16'h88EF);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_prod", {16'd0, product_out}, 32'd0);
        chk("midrst_done", {31'd0, done_flag}, 32'd0);
        do_op(8'hAB, 8'hCD, 16'h88EF);
        wait_done();

        // zero operand
        do_op(8'h00, 8'h5A, 16'h0000);
        wait_done();
        chk("zero_done", {31'd0, done_flag}, 32'd1);

        chk("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
